pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback).
- Tracks one valid bit per stage and generates PC enable, IF/DE hold, and bubble-injection (flush) controls.
- Resolves load-use stalls and taken-branch flushes.
- Implements halt-drain and single-step, and keeps cycle and retired-instruction counters for debug visibility.

Parameters:
- CNT_W, 32, width of cycle_count and retired_count.
- REG_W, 4, width of register-index fields.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  level request: stop fetching, drain, hold in HALTED while high.
- step  in  1  one-cycle pulse; honoured only in HALTED: issue exactly one instruction.
- branch_taken_exe  in  1  taken branch / PC write resolved in execute stage.
- exe_mem_to_reg  in  1  instruction in execute is a load.
- exe_rd  in  REG_W  destination register of instruction in execute.
- deco_ra1, deco_ra2  in  REG_W  source registers of instruction in decode.
- deco_use_a1, deco_use_a2  in  1  decode actually reads ra1 / ra2.
- pc_en  out  1  PC register load enable.
- if_de_en  out  1  IF/DE register load enable (0 = hold).
- if_de_flush  out  1  IF/DE loads a bubble.
- deco_exe_flush  out  1  DE/EXE loads a bubble.
- state  out  2  RUN=0, DRAIN=1, HALTED=2, STEP=3.
- halted  out  1  state==HALTED.
- stage_valid  out  4  {v_wb, v_mem, v_ex, v_de}.
- cycle_count  out  CNT_W  cycles spent outside HALTED.
- retired_count  out  CNT_W  instructions that completed writeback.

Behaviour:
- Reset (async, reset=0):
  - state=RUN; all valid bits 0; both counters 0.
  - Outputs during and immediately after reset: pc_en=1, if_de_en=1, flushes 0.
- fetch_active = (state==RUN or STEP).
- Qualified hazards:
  - br = branch_taken_exe & v_ex.
  - lu = v_de & v_ex & exe_mem_to_reg & ((deco_use_a1 & deco_ra1==exe_rd) | (deco_use_a2 & deco_ra2==exe_rd)).
- Control output priority (combinational), highest first:
  - br: pc_en=1 (target load), if_de_en=1, if_de_flush=1, deco_exe_flush=1. Kills the two younger instructions; applies in every state, including DRAIN.
  - lu: pc_en=0, if_de_en=0, if_de_flush=0, deco_exe_flush=1. Exactly one bubble.
  - fetch_active: pc_en=1, if_de_en=1, no flush.
  - Otherwise (DRAIN/HALTED): pc_en=0, if_de_en=1, if_de_flush=1 (bubbles).
- Valid-bit update each edge:
  - v_wb<=v_mem; v_mem<=v_ex.
  - v_ex <= deco_exe_flush ? 0 : v_de.
  - v_de <= if_de_flush ? 0 : (if_de_en ? fetch_active : v_de).
- FSM:
  - RUN: halt=1 -> DRAIN.
  - DRAIN: when next-cycle v_de..v_wb all 0 -> HALTED. halt dropping in DRAIN -> RUN immediately.
  - HALTED:
    - halt=0 -> RUN.
    - else step=1 -> STEP.
    - step outside HALTED is ignored (no latching).
  - STEP: stays while lu (fetch not accepted); otherwise -> DRAIN after one accepted fetch. Any br during the drain is still honoured.
- Counters:
  - cycle_count += 1 each edge with state!=HALTED.
  - retired_count += 1 each edge with v_wb=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - halt and br in the same cycle: br outputs apply; state -> DRAIN.
  - step and halt deassertion in the same cycle: halt deassertion wins (-> RUN).
- Reset mid-operation: immediate return to reset values; in-flight instructions are discarded (valid bits cleared).

Test Plan:
1. Release reset with no hazards, halt=0 -> state=0, pc_en=1. stage_valid goes 0001, 0011, 0111, 1111 on edges 1-4; retired_count=1 after edge 5, then +1 per edge.
2. Steady run, one load-use hazard (exe_mem_to_reg=1, exe_rd=3, deco_ra1=3, deco_use_a1=1) -> for one cycle pc_en=0, if_de_en=0, deco_exe_flush=1. Next cycle normal. Exactly one 0 appears in v_ex.
3. branch_taken_exe=1 with v_ex=1 -> pc_en=1, if_de_flush=1, deco_exe_flush=1 that cycle. Over 10 cycles, retired_count advances by 2 less than with no branch.
4. Full pipeline, assert halt -> state=1, pc_en=0 next cycle. state=2 and halted=1 after 4 drain edges. cycle_count then frozen; retired_count frozen once v_wb=0.
5. In HALTED with halt=1, pulse step -> state 3 for one cycle, then 1, then 2. retired_count increases by exactly 1. A second step pulse in DRAIN is ignored.
6. Drive reset=0 asynchronously mid-DRAIN -> state=0, stage_valid=0000, counters=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_controller.sv
// Sequencing controller for a 5-stage pipeline: stage valid tracking, load-use
// stall, branch flush, halt-drain / single-step FSM and debug counters.
module pipeline_controller #(
    parameter int CNT_W = 32,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             step,
    input  logic             branch_taken_exe,
    input  logic             exe_mem_to_reg,
    input  logic [REG_W-1:0] exe_rd,
    input  logic [REG_W-1:0] deco_ra1,
    input  logic [REG_W-1:0] deco_ra2,
    input  logic             deco_use_a1,
    input  logic             deco_use_a2,
    output logic             pc_en,
    output logic             if_de_en,
    output logic             if_de_flush,
    output logic             deco_exe_flush,
    output logic [1:0]       state,
    output logic             halted,
    output logic [3:0]       stage_valid,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic v_de, v_ex, v_mem, v_wb;
    logic v_de_d, v_ex_d;
    logic fetch_active;
    logic br, lu;
    logic src1_hit, src2_hit;
    logic drained;

    assign fetch_active = (state_q == RUN) || (state_q == STEP);

    assign src1_hit = deco_use_a1 && (deco_ra1 == exe_rd);
    assign src2_hit = deco_use_a2 && (deco_ra2 == exe_rd);

    assign br = branch_taken_exe && v_ex;
    assign lu = v_de && v_ex && exe_mem_to_reg && (src1_hit || src2_hit);

    // Hazard priority: branch kill > load-use bubble > normal fetch > drain bubbles.
    always_comb begin
        pc_en          = 1'b1;
        if_de_en       = 1'b1;
        if_de_flush    = 1'b0;
        deco_exe_flush = 1'b0;
        if (br) begin
            if_de_flush    = 1'b1;
            deco_exe_flush = 1'b1;
        end else if (lu) begin
            pc_en          = 1'b0;
            if_de_en       = 1'b0;
            deco_exe_flush = 1'b1;
        end else if (!fetch_active) begin
            pc_en       = 1'b0;
            if_de_flush = 1'b1;
        end
    end

    always_comb begin
        v_ex_d = deco_exe_flush ? 1'b0 : v_de;
        if (if_de_flush) begin
            v_de_d = 1'b0;
        end else if (if_de_en) begin
            v_de_d = fetch_active;
        end else begin
            v_de_d = v_de;
        end
    end

    // Next-cycle v_mem/v_wb are the current v_ex/v_mem.
    assign drained = !(v_de_d || v_ex_d || v_ex || v_mem);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt) begin
                    state_d = RUN;
                end else if (drained) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (!lu) state_d = DRAIN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_de  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            v_de  <= v_de_d;
            v_ex  <= v_ex_d;
            v_mem <= v_ex;
            v_wb  <= v_mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state_q != HALTED) cycle_count <= cycle_count + CNT_W'(1);
            if (v_wb) retired_count <= retired_count + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == HALTED);
    assign stage_valid = {v_wb, v_mem, v_ex, v_de};

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed + randomized bench for pipeline_controller against a token-based
// pipeline model (each in-flight instruction carries an id, 0 = empty slot).
module tb_pipeline_controller;

    localparam int CNT_W = 32;
    localparam int REG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             halt, step, branch_taken_exe, exe_mem_to_reg;
    logic [REG_W-1:0] exe_rd, deco_ra1, deco_ra2;
    logic             deco_use_a1, deco_use_a2;
    logic             pc_en, if_de_en, if_de_flush, deco_exe_flush, halted;
    logic [1:0]       state;
    logic [3:0]       stage_valid;
    logic [CNT_W-1:0] cycle_count, retired_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_controller #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .halt(halt), .step(step),
        .branch_taken_exe(branch_taken_exe), .exe_mem_to_reg(exe_mem_to_reg),
        .exe_rd(exe_rd), .deco_ra1(deco_ra1), .deco_ra2(deco_ra2),
        .deco_use_a1(deco_use_a1), .deco_use_a2(deco_use_a2),
        .pc_en(pc_en), .if_de_en(if_de_en), .if_de_flush(if_de_flush),
        .deco_exe_flush(deco_exe_flush), .state(state), .halted(halted),
        .stage_valid(stage_valid), .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    // Model: tok[0]=decode .. tok[3]=writeback holding instruction ids.
    int               tok[4];
    int               next_id;
    int               m_state;
    logic [CNT_W-1:0] m_cyc, m_ret;
    logic             e_pc, e_ifen, e_iff, e_dxf, m_lu;
    logic [3:0]       fill_seq[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) tok[i] = 0;
        next_id = 1;
        m_state = 0;
        m_cyc   = '0;
        m_ret   = '0;
    endtask

    task automatic model_eval();
        logic m_br, fetch, hit;
        fetch = (m_state == 0) || (m_state == 3);
        m_br  = branch_taken_exe && (tok[1] != 0);
        hit   = (deco_use_a1 && deco_ra1 == exe_rd) || (deco_use_a2 && deco_ra2 == exe_rd);
        m_lu  = (tok[0] != 0) && (tok[1] != 0) && exe_mem_to_reg && hit;
        if (m_br)       {e_pc, e_ifen, e_iff, e_dxf} = 4'b1111;
        else if (m_lu)  {e_pc, e_ifen, e_iff, e_dxf} = 4'b0001;
        else if (fetch) {e_pc, e_ifen, e_iff, e_dxf} = 4'b1100;
        else            {e_pc, e_ifen, e_iff, e_dxf} = 4'b0110;
    endtask

    task automatic cycle();
        int  n[4];
        int  ns;
        logic fetch;
        #1;
        model_eval();
        chk("pc_en", pc_en, e_pc);
        chk("if_de_en", if_de_en, e_ifen);
        chk("if_de_flush", if_de_flush, e_iff);
        chk("deco_exe_flush", deco_exe_flush, e_dxf);
        chk("state", state, m_state);
        chk("halted", halted, m_state == 2);
        chk("stage_valid", stage_valid, {tok[3] != 0, tok[2] != 0, tok[1] != 0, tok[0] != 0});
        chk("cycle_count", cycle_count, m_cyc);
        chk("retired_count", retired_count, m_ret);

        fetch = (m_state == 0) || (m_state == 3);
        n[3] = tok[2];
        n[2] = tok[1];
        n[1] = e_dxf ? 0 : tok[0];
        if (e_iff) n[0] = 0;
        else if (e_ifen) n[0] = fetch ? next_id : 0;
        else n[0] = tok[0];
        if (n[0] == next_id && n[0] != 0) next_id++;

        ns = m_state;
        case (m_state)
            0: if (halt) ns = 1;
            1: if (!halt) ns = 0;
               else if (n[0] == 0 && n[1] == 0 && n[2] == 0 && n[3] == 0) ns = 2;
            2: if (!halt) ns = 0; else if (step) ns = 3;
            default: if (!m_lu) ns = 1;
        endcase

        @(posedge clk);
        if (m_state != 2) m_cyc = m_cyc + 1;
        if (tok[3] != 0) m_ret = m_ret + 1;
        for (int i = 0; i < 4; i++) tok[i] = n[i];
        m_state = ns;
        @(negedge clk);
    endtask

    task automatic clear_hazards();
        branch_taken_exe = 1'b0;
        exe_mem_to_reg   = 1'b0;
        exe_rd           = '0;
        deco_ra1         = 4'd1;
        deco_ra2         = 4'd2;
        deco_use_a1      = 1'b0;
        deco_use_a2      = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, state, 2'd0);
        chk({tag, "_valid"}, stage_valid, 4'b0000);
        chk({tag, "_cyc"}, cycle_count, 0);
        chk({tag, "_ret"}, retired_count, 0);
        chk({tag, "_pc_en"}, pc_en, 1'b1);
        chk({tag, "_if_de_en"}, if_de_en, 1'b1);
        chk({tag, "_flushes"}, {if_de_flush, deco_exe_flush}, 2'b00);
    endtask

    initial begin
        fill_seq[0] = 4'b0001;
        fill_seq[1] = 4'b0011;
        fill_seq[2] = 4'b0111;
        fill_seq[3] = 4'b1111;
        reset = 1'b0;
        halt  = 1'b0;
        step  = 1'b0;
        clear_hazards();
        m_reset();

        // Reset state, then fill.
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fill_seq", stage_valid, fill_seq[i]);
        end
        for (int i = 0; i < 4; i++) cycle();

        // Load-use on ra1, then on ra2.
        exe_mem_to_reg = 1'b1; exe_rd = 4'd3; deco_ra1 = 4'd3; deco_use_a1 = 1'b1;
        cycle();
        clear_hazards();
        for (int i = 0; i < 3; i++) cycle();
        exe_mem_to_reg = 1'b1; exe_rd = 4'd5; deco_ra2 = 4'd5; deco_use_a2 = 1'b1;
        cycle();
        clear_hazards();
        for (int i = 0; i < 3; i++) cycle();

        // Taken branch.
        branch_taken_exe = 1'b1;
        cycle();
        clear_hazards();
        for (int i = 0; i < 10; i++) cycle();

        // Halt drain from full pipeline.
        halt = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("halt_reached", state, 2'd2);
        for (int i = 0; i < 3; i++) cycle();

        // Single step, plus a step pulse during the following drain.
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("step_rehalted", halted, 1'b1);

        // Release halt together with a step pulse.
        halt = 1'b0; step = 1'b1;
        cycle();
        step = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            step             = ($urandom_range(0, 5) == 0);
            branch_taken_exe = ($urandom_range(0, 6) == 0);
            exe_mem_to_reg   = ($urandom_range(0, 2) == 0);
            exe_rd           = REG_W'($urandom_range(0, 3));
            deco_ra1         = REG_W'($urandom_range(0, 3));
            deco_ra2         = REG_W'($urandom_range(0, 3));
            deco_use_a1      = 1'($urandom_range(0, 1));
            deco_use_a2      = 1'($urandom_range(0, 1));
            cycle();
        end

        // Asynchronous reset mid-drain.
        halt = 1'b0; step = 1'b0;
        clear_hazards();
        for (int i = 0; i < 8; i++) cycle();
        halt = 1'b1;
        cycle();
        cycle();
        chk("pre_reset_drain", state, 2'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        halt  = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
